lsu: RTL and testbench

- Load/store stage directly downstream of the execute unit.
- Takes the ALU result as the effective address (or as pass-through data for non-memory ops), plus rs2 data and funct3.
- Runs one transaction per instruction on a valid/ready memory bus: byte-lane alignment, write strobes, load extraction with sign/zero extension.
- Hands the result to write-back through a valid/ready handshake.

---
 rtl/lsu.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_lsu.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit sitting directly after execute.
// Each accepted instruction is decoded once. It either completes locally
// (pass-through or exception) or runs one valid/ready bus transaction.
// The formatted result is then offered to write-back on a valid/ready handshake.
// Every bus and result output comes straight from a flop.

module lsu #(
    parameter int unsigned BUS_LAT_MAX = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_rs2_data,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata,
    input  logic        rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic [1:0]  out_err_code
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS      = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // A zero limit disables the response watchdog entirely.
    localparam bit          TMO_EN   = (BUS_LAT_MAX != 32'd0);
    localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(BUS_LAT_MAX - 32'd1) : 16'd0;

    // funct3 codes that RV32 defines for the given access direction.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        logic ok;
        if (is_load) begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
                default:                                ok = 1'b0;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b001, 3'b010: ok = 1'b1;
                default:                ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Natural alignment check. The size is funct3[1:0]: 0 = byte, 1 = half, 2 = word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Replicate store data across every lane it may land in.
    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{rs2[7:0]}};
            2'b01:   d = {2{rs2[15:0]}};
            default: d = rs2;
        endcase
        return d;
    endfunction

    // Byte-enable mask for the lanes touched by a store.
    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] s;
        case (size)
            2'b00:   s = 4'b0001 << off;
            2'b01:   s = 4'b0011 << off;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Pull the addressed lanes out of the read word and extend them.
    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b100:  r = {24'h000000, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            3'b010:  r = rdata;
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

    state_t      state_r,        state_nxt_s;
    logic        req_valid_r,    req_valid_nxt_s;
    logic        req_we_r,       req_we_nxt_s;
    logic [31:0] req_addr_r,     req_addr_nxt_s;
    logic [31:0] req_wdata_r,    req_wdata_nxt_s;
    logic [3:0]  req_wstrb_r,    req_wstrb_nxt_s;
    logic        out_valid_r,    out_valid_nxt_s;
    logic [31:0] out_data_r,     out_data_nxt_s;
    logic        out_err_r,      out_err_nxt_s;
    logic [1:0]  out_code_r,     out_code_nxt_s;
    logic [2:0]  funct3_r,       funct3_nxt_s;
    logic [1:0]  off_r,          off_nxt_s;
    logic [15:0] tmo_cnt_r,      tmo_cnt_nxt_s;

    assign in_ready     = (state_r == S_IDLE);
    assign req_valid    = req_valid_r;
    assign req_we       = req_we_r;
    assign req_addr     = req_addr_r;
    assign req_wdata    = req_wdata_r;
    assign req_wstrb    = req_wstrb_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_err      = out_err_r;
    assign out_err_code = out_code_r;

    // Next-state and next-register values; everything holds unless a transition says otherwise.
    always_comb begin
        state_nxt_s     = state_r;
        req_valid_nxt_s = req_valid_r;
        req_we_nxt_s    = req_we_r;
        req_addr_nxt_s  = req_addr_r;
        req_wdata_nxt_s = req_wdata_r;
        req_wstrb_nxt_s = req_wstrb_r;
        out_valid_nxt_s = out_valid_r;
        out_data_nxt_s  = out_data_r;
        out_err_nxt_s   = out_err_r;
        out_code_nxt_s  = out_code_r;
        funct3_nxt_s    = funct3_r;
        off_nxt_s       = off_r;
        tmo_cnt_nxt_s   = tmo_cnt_r;

        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    funct3_nxt_s   = in_funct3;
                    off_nxt_s      = in_alu_result[1:0];
                    tmo_cnt_nxt_s  = 16'd0;
                    out_data_nxt_s = 32'h00000000;
                    out_err_nxt_s  = 1'b0;
                    out_code_nxt_s = ERR_NONE;
                    if (in_is_load && in_is_store) begin
                        state_nxt_s     = S_DONE;
                        out_valid_nxt_s = 1'b1;
                        out_err_nxt_s   = 1'b1;
                        out_code_nxt_s  = ERR_ILLEGAL;
                    end else if (!in_is_load && !in_is_store) begin
                        state_nxt_s     = S_DONE;
                        out_valid_nxt_s = 1'b1;
                        out_data_nxt_s  = in_alu_result;
                    end else if (!f3_legal(in_is_load, in_funct3)) begin
                        state_nxt_s     = S_DONE;
                        out_valid_nxt_s = 1'b1;
                        out_err_nxt_s   = 1'b1;
                        out_code_nxt_s  = ERR_ILLEGAL;
                    end else if (is_misaligned(in_funct3[1:0], in_alu_result[1:0])) begin
                        state_nxt_s     = S_DONE;
                        out_valid_nxt_s = 1'b1;
                        out_err_nxt_s   = 1'b1;
                        out_code_nxt_s  = ERR_MISALIGN;
                    end else begin
                        state_nxt_s     = S_REQ;
                        req_valid_nxt_s = 1'b1;
                        req_we_nxt_s    = in_is_store;
                        req_addr_nxt_s  = {in_alu_result[31:2], 2'b00};
                        if (in_is_store) begin
                            req_wdata_nxt_s = store_wdata(in_funct3[1:0], in_rs2_data);
                            req_wstrb_nxt_s = store_strb(in_funct3[1:0], in_alu_result[1:0]);
                        end else begin
                            req_wdata_nxt_s = 32'h00000000;
                            req_wstrb_nxt_s = 4'b0000;
                        end
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (req_ready) begin
                    state_nxt_s     = S_WAIT;
                    req_valid_nxt_s = 1'b0;
                    tmo_cnt_nxt_s   = 16'd0;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    state_nxt_s     = S_DONE;
                    out_valid_nxt_s = 1'b1;
                    if (rsp_err) begin
                        out_data_nxt_s = 32'h00000000;
                        out_err_nxt_s  = 1'b1;
                        out_code_nxt_s = ERR_BUS;
                    end else if (req_we_r) begin
                        out_data_nxt_s = 32'h00000000;
                    end else begin
                        out_data_nxt_s = load_format(funct3_r, off_r, rsp_rdata);
                    end
                end else if (TMO_EN && (tmo_cnt_r == TMO_LAST)) begin
                    state_nxt_s     = S_DONE;
                    out_valid_nxt_s = 1'b1;
                    out_data_nxt_s  = 32'h00000000;
                    out_err_nxt_s   = 1'b1;
                    out_code_nxt_s  = ERR_BUS;
                end else if (TMO_EN) begin
                    tmo_cnt_nxt_s = tmo_cnt_r + 16'd1;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt_s     = S_IDLE;
                    out_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            default: begin
                state_nxt_s     = S_IDLE;
                req_valid_nxt_s = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            req_valid_r <= 1'b0;
            req_we_r    <= 1'b0;
            req_addr_r  <= 32'h00000000;
            req_wdata_r <= 32'h00000000;
            req_wstrb_r <= 4'b0000;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'h00000000;
            out_err_r   <= 1'b0;
            out_code_r  <= 2'b00;
            funct3_r    <= 3'b000;
            off_r       <= 2'b00;
            tmo_cnt_r   <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            req_valid_r <= req_valid_nxt_s;
            req_we_r    <= req_we_nxt_s;
            req_addr_r  <= req_addr_nxt_s;
            req_wdata_r <= req_wdata_nxt_s;
            req_wstrb_r <= req_wstrb_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_err_r   <= out_err_nxt_s;
            out_code_r  <= out_code_nxt_s;
            funct3_r    <= funct3_nxt_s;
            off_r       <= off_nxt_s;
            tmo_cnt_r   <= tmo_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases followed by randomized instructions.
// Expected values come from a behavioural model of the load/store rules.

module tb_lsu;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_load = 1'b0;
    logic        in_is_store = 1'b0;
    logic [2:0]  in_funct3 = 3'b000;
    logic [31:0] in_alu_result = 32'h0;
    logic [31:0] in_rs2_data = 32'h0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_rdata = 32'h0;
    logic        rsp_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_err;
    logic [1:0]  out_err_code;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu #(.BUS_LAT_MAX(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_rs2_data(in_rs2_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .out_err_code(out_err_code)
    );

    typedef struct packed {
        logic        bus;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] data;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outcome of one instruction, derived from the architectural rules.
    function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] rs2,
                                   input logic [31:0] rdata, input logic rerr, input bit tmo);
        exp_t e;
        int unsigned off, nbytes, b, span;
        logic [31:0] sh;
        bit legal;
        e = '0;
        off = addr % 32'd4;
        nbytes = 32'd1 << f3[1:0];
        if (ld && st) begin
            e.err = 1'b1; e.code = 2'b11; return e;
        end
        if (!ld && !st) begin
            e.data = addr; return e;
        end
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) begin
            e.err = 1'b1; e.code = 2'b11; return e;
        end
        if ((off % nbytes) != 0) begin
            e.err = 1'b1; e.code = 2'b01; return e;
        end
        e.bus = 1'b1;
        e.we = st;
        e.addr = addr - off;
        if (st) begin
            e.wstrb = 4'(((32'd1 << nbytes) - 32'd1) << off);
            if (nbytes == 1)      e.wdata = rs2[7:0] * 32'h01010101;
            else if (nbytes == 2) e.wdata = rs2[15:0] * 32'h00010001;
            else                  e.wdata = rs2;
        end
        if (tmo || rerr) begin
            e.err = 1'b1; e.code = 2'b10; e.data = 32'h0;
        end else if (ld) begin
            sh = rdata >> (8 * off);
            if (nbytes == 4) begin
                e.data = rdata;
            end else begin
                span = 32'd1 << (8 * nbytes);
                b = sh % span;
                if (!f3[2] && b >= span / 2) e.data = b - span;
                else                         e.data = b;
            end
        end
        return e;
    endfunction

    // One full instruction: issue, bus phase (if any), result handshake. Starts and ends on a negedge.
    task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                           input logic rerr, input int req_d, input int rsp_d, input int out_d,
                           input bit stray);
        exp_t e;
        bit tmo;
        tmo = (rsp_d >= int'(LAT));
        e = model(ld, st, f3, addr, rs2, rdata, rerr, tmo);
        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st;
        in_funct3 = f3; in_alu_result = addr; in_rs2_data = rs2;
        @(negedge clk);
        in_valid = 1'b0; in_is_load = 1'($urandom); in_is_store = 1'($urandom);
        in_funct3 = 3'($urandom); in_alu_result = $urandom; in_rs2_data = $urandom;
        check("in_ready_busy", in_ready, 1'b0);
        if (e.bus) begin
            for (int k = 0; k <= req_d; k++) begin
                check("req_valid", req_valid, 1'b1);
                check("req_we", req_we, e.we);
                check("req_addr", req_addr, e.addr);
                check("req_wstrb", req_wstrb, e.wstrb);
                if (st) check("req_wdata", req_wdata, e.wdata);
                check("out_valid_in_req", out_valid, 1'b0);
                if (k == req_d) begin
                    req_ready = 1'b1;
                end else begin
                    rsp_valid = stray; rsp_err = 1'b1; rsp_rdata = $urandom;
                end
                @(negedge clk);
                rsp_valid = 1'b0; rsp_err = 1'b0;
            end
            req_ready = 1'b0;
            check("req_drop", req_valid, 1'b0);
            for (int k = 0; k < int'(LAT); k++) begin
                if (!tmo && k == rsp_d) begin
                    rsp_valid = 1'b1; rsp_rdata = rdata; rsp_err = rerr;
                end
                check("out_valid_in_wait", out_valid, 1'b0);
                @(negedge clk);
                rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = $urandom;
                if (!tmo && k == rsp_d) break;
            end
        end
        for (int k = 0; k <= out_d; k++) begin
            check("out_valid", out_valid, 1'b1);
            check("out_data", out_data, e.data);
            check("out_err", out_err, e.err);
            check("out_err_code", out_err_code, e.code);
            check("in_ready_done", in_ready, 1'b0);
            check("req_valid_done", req_valid, 1'b0);
            if (k == out_d) begin
                out_ready = 1'b1;
            end else begin
                rsp_valid = stray; rsp_err = 1'($urandom); rsp_rdata = $urandom;
            end
            @(negedge clk);
            rsp_valid = 1'b0; rsp_err = 1'b0;
        end
        out_ready = 1'b0;
        check("out_valid_after", out_valid, 1'b0);
        check("in_ready_after", in_ready, 1'b1);
    endtask

    // Directed steps, reset scenarios, then randomized traffic.
    initial begin
        logic        ld, st, rerr;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          r, rsp_d;

        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_out_code", out_err_code, 2'b00);
        check("rst_out_data", out_data, 32'h0);
        check("rst_req_addr", req_addr, 32'h0);
        check("rst_req_wstrb", req_wstrb, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(1'b0, 1'b0, 3'b000, 32'h12345678, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0);
        run_txn(1'b1, 1'b0, 3'b000, 32'h80000003, 32'h0, 32'h80FF7F01, 1'b0, 0, 0, 0, 1'b0);
        run_txn(1'b1, 1'b0, 3'b100, 32'h80000003, 32'h0, 32'h80FF7F01, 1'b0, 0, 0, 0, 1'b0);
        run_txn(1'b0, 1'b1, 3'b001, 32'h00000100, 32'hAABBCCDD, 32'h0, 1'b0, 0, 0, 0, 1'b0);
        run_txn(1'b0, 1'b1, 3'b001, 32'h00000102, 32'hAABBCCDD, 32'h0, 1'b0, 0, 0, 0, 1'b0);
        run_txn(1'b1, 1'b0, 3'b010, 32'h00000200, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, 2, 1'b1);
        run_txn(1'b1, 1'b0, 3'b010, 32'h00000102, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0);
        run_txn(1'b1, 1'b0, 3'b010, 32'h00000300, 32'h0, 32'h55AA55AA, 1'b1, 0, 1, 0, 1'b0);
        run_txn(1'b1, 1'b0, 3'b011, 32'h00000300, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0);
        run_txn(1'b1, 1'b0, 3'b010, 32'h00000400, 32'h0, 32'h0, 1'b0, 0, 6, 0, 1'b0);
        run_txn(1'b1, 1'b1, 3'b010, 32'h00000400, 32'h0, 32'h0, 1'b0, 0, 0, 0, 1'b0);

        // Reset while a request is pending: req_valid must drop without a clock edge.
        in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0;
        in_funct3 = 3'b010; in_alu_result = 32'h00000400;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_req_valid", req_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_req_valid", req_valid, 1'b0);
        check("rst_req_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while waiting for the response, then a stray response afterwards.
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_wait_out_valid", out_valid, 1'b0);
        check("rst_wait_req_valid", req_valid, 1'b0);
        check("rst_wait_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_valid = 1'b1; rsp_rdata = 32'h13579BDF;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("stray_rsp_out_valid", out_valid, 1'b0);
        check("stray_rsp_in_ready", in_ready, 1'b1);
        run_txn(1'b1, 1'b0, 3'b010, 32'h00000500, 32'h0, 32'h0BADF00D, 1'b0, 0, 0, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            ld = (r < 4) || (r == 9);
            st = ((r >= 4) && (r < 8)) || (r == 9);
            if ($urandom_range(0, 9) < 7) begin
                f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
                if (!st && f3 == 3'd3) f3 = 3'd4;
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            rerr = ($urandom_range(0, 7) == 0);
            rsp_d = ($urandom_range(0, 9) == 0) ? 4 + $urandom_range(0, 1) : $urandom_range(0, 3);
            run_txn(ld, st, f3, addr, $urandom, $urandom, rerr,
                    $urandom_range(0, 3), rsp_d, $urandom_range(0, 3), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
